// File: rtl/pu_config_regfile_pkg.sv
// ============================================================================
// Module   : pu_cfg_pkg
// Brief    : Register offsets, response codes and policy-bit helpers shared
//            by the Protection Unit configuration register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pu_cfg_pkg;

    localparam logic [15:0] c_OFF_SCRATCH   = 16'h0000;
    localparam logic [15:0] c_OFF_VIOL_CNT  = 16'h0004;
    localparam logic [15:0] c_OFF_VIOL_ADDR = 16'h0008;
    localparam logic [15:0] c_OFF_VIOL_INFO = 16'h000C;
    localparam logic [15:0] c_OFF_POLICY    = 16'h0040;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_e;

    typedef enum logic [2:0] {
        SEL_SCRATCH   = 3'd0,
        SEL_VIOL_CNT  = 3'd1,
        SEL_VIOL_ADDR = 3'd2,
        SEL_VIOL_INFO = 3'd3,
        SEL_POLICY    = 3'd4,
        SEL_NONE      = 3'd5
    } sel_e;

    function automatic int unsigned pol_wr_bit(input int unsigned i);
        return 2 + 2 * i;
    endfunction

    function automatic int unsigned pol_rd_bit(input int unsigned i);
        return 3 + 2 * i;
    endfunction

    // Only the bits that map to a policed ID are storable; everything else reads 0.
    function automatic logic [31:0] pol_mask(input int unsigned num_ids);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < num_ids; i++) begin
            m[5'(pol_wr_bit(i))] = 1'b1;
            m[5'(pol_rd_bit(i))] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [31:0] strb_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pu_config_regfile_if.sv
// ============================================================================
// Module   : pu_config_regfile_if
// Brief    : AXI4-Lite bundle between the config master and the PU regfile.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pu_config_regfile_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

`default_nettype wire

// File: rtl/pu_config_regfile_viol_counter.sv
// ============================================================================
// Module   : pu_viol_counter
// Brief    : Saturating violation counter with last-report address/info capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_viol_counter #(
    parameter int CNT_W = 16
) (
    input  wire               clk,
    input  wire               rst_n,
    input  wire               i_clr,
    input  wire               i_viol_valid,
    input  wire  [31:0]       i_viol_addr,
    input  wire  [3:0]        i_viol_id,
    input  wire               i_viol_is_write,
    output logic [CNT_W-1:0]  o_cnt,
    output logic [31:0]       o_addr,
    output logic [4:0]        o_info
);
    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_addr;
    logic [4:0]       r_info;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_addr <= '0;
            r_info <= '0;
        end else begin
            // A clear that coincides with a report still counts that report.
            if (i_clr) begin
                r_cnt <= i_viol_valid ? CNT_W'(1) : '0;
            end else if (i_viol_valid && (r_cnt != '1)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (i_viol_valid) begin
                r_addr <= i_viol_addr;
                r_info <= {i_viol_is_write, i_viol_id};
            end
        end
    end

    assign o_cnt  = r_cnt;
    assign o_addr = r_addr;
    assign o_info = r_info;

endmodule

`default_nettype wire

// File: rtl/pu_config_regfile.sv
// ============================================================================
// Module   : pu_config_regfile
// Brief    : AXI4-Lite register file programming one Protection Unit's policy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pu_config_regfile
    import pu_cfg_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int NUM_IDS = 2,
    parameter int CNT_W   = 16
) (
    input  wire                  aclk,
    input  wire                  aresetn,
    pu_config_regfile_if.slave   s_axi,
    input  wire                  viol_valid_i,
    input  wire  [31:0]          viol_addr_i,
    input  wire  [3:0]           viol_id_i,
    input  wire                  viol_is_write_i,
    output logic [NUM_IDS-1:0]   policy_rd_o,
    output logic [NUM_IDS-1:0]   policy_wr_o,
    output logic                 policy_upd_o
);
    localparam logic [31:0] c_POL_MASK = pol_mask(NUM_IDS);

    typedef enum logic [1:0] {
        WR_IDLE    = 2'd0,
        WR_HOLD_AW = 2'd1,
        WR_HOLD_W  = 2'd2,
        WR_RESP    = 2'd3
    } wr_state_e;

    typedef enum logic [0:0] {
        RD_IDLE = 1'b0,
        RD_RESP = 1'b1
    } rd_state_e;

    function automatic sel_e decode(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] word;
        sel_e              sel;
        word      = a;
        word[1:0] = 2'b00;
        case (word)
            ADDR_W'(c_OFF_SCRATCH):   sel = SEL_SCRATCH;
            ADDR_W'(c_OFF_VIOL_CNT):  sel = SEL_VIOL_CNT;
            ADDR_W'(c_OFF_VIOL_ADDR): sel = SEL_VIOL_ADDR;
            ADDR_W'(c_OFF_VIOL_INFO): sel = SEL_VIOL_INFO;
            ADDR_W'(c_OFF_POLICY):    sel = SEL_POLICY;
            default:                  sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    wr_state_e         r_wr_state, w_wr_state_nxt;
    rd_state_e         r_rd_state, w_rd_state_nxt;
    logic              r_aw_full, r_w_full, w_aw_full_nxt, w_w_full_nxt;
    logic              r_awready, r_wready, r_arready;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata, r_scratch, r_policy, r_rdata, w_rd_word;
    logic [3:0]        r_wstrb;
    resp_e             r_bresp, r_rresp;
    logic              r_policy_upd;
    logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_cnt_clr;
    sel_e              w_wsel, w_rsel;
    logic [CNT_W-1:0]  w_viol_cnt;
    logic [31:0]       w_viol_addr;
    logic [4:0]        w_viol_info;

    assign w_aw_hs   = s_axi.awvalid & r_awready;
    assign w_w_hs    = s_axi.wvalid & r_wready;
    assign w_ar_hs   = s_axi.arvalid & r_arready;
    assign w_wsel    = decode(r_awaddr);
    assign w_rsel    = decode(s_axi.araddr);
    assign w_commit  = r_aw_full & r_w_full & (r_wr_state != WR_RESP);
    assign w_cnt_clr = w_commit & (w_wsel == SEL_VIOL_CNT);

    // Holding regs refill independently of the B phase; the state only gates commit.
    always_comb begin
        w_aw_full_nxt  = r_aw_full;
        w_w_full_nxt   = r_w_full;
        w_wr_state_nxt = r_wr_state;
        if (w_commit) begin
            w_aw_full_nxt = 1'b0;
            w_w_full_nxt  = 1'b0;
        end
        if (w_aw_hs) w_aw_full_nxt = 1'b1;
        if (w_w_hs)  w_w_full_nxt  = 1'b1;
        if (w_commit || (r_wr_state == WR_RESP && !s_axi.bready)) begin
            w_wr_state_nxt = WR_RESP;
        end else begin
            case ({w_aw_full_nxt, w_w_full_nxt})
                2'b10:   w_wr_state_nxt = WR_HOLD_AW;
                2'b01:   w_wr_state_nxt = WR_HOLD_W;
                default: w_wr_state_nxt = WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wr_state   <= WR_IDLE;
            r_aw_full    <= 1'b0;
            r_w_full     <= 1'b0;
            r_awready    <= 1'b0;
            r_wready     <= 1'b0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_bresp      <= OKAY;
            r_scratch    <= '0;
            r_policy     <= '0;
            r_policy_upd <= 1'b0;
        end else begin
            r_wr_state   <= w_wr_state_nxt;
            r_aw_full    <= w_aw_full_nxt;
            r_w_full     <= w_w_full_nxt;
            r_awready    <= ~w_aw_full_nxt;
            r_wready     <= ~w_w_full_nxt;
            r_policy_upd <= w_commit & (w_wsel == SEL_POLICY);
            if (w_aw_hs) r_awaddr <= s_axi.awaddr;
            if (w_w_hs) begin
                r_wdata <= s_axi.wdata;
                r_wstrb <= s_axi.wstrb;
            end
            if (w_commit) begin
                r_bresp <= (w_wsel == SEL_NONE) ? SLVERR : OKAY;
                if (w_wsel == SEL_SCRATCH) r_scratch <= strb_merge(r_scratch, r_wdata, r_wstrb);
                if (w_wsel == SEL_POLICY)
                    r_policy <= strb_merge(r_policy, r_wdata, r_wstrb) & c_POL_MASK;
            end
        end
    end

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        if (r_rd_state == RD_IDLE && w_ar_hs)          w_rd_state_nxt = RD_RESP;
        else if (r_rd_state == RD_RESP && s_axi.rready) w_rd_state_nxt = RD_IDLE;
    end

    always_comb begin
        w_rd_word = '0;
        case (w_rsel)
            SEL_SCRATCH:   w_rd_word = r_scratch;
            SEL_VIOL_CNT:  w_rd_word = 32'(w_viol_cnt);
            SEL_VIOL_ADDR: w_rd_word = w_viol_addr;
            SEL_VIOL_INFO: w_rd_word = {27'b0, w_viol_info};
            SEL_POLICY:    w_rd_word = r_policy;
            default:       w_rd_word = '0;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rd_state <= RD_IDLE;
            r_arready  <= 1'b0;
            r_rdata    <= '0;
            r_rresp    <= OKAY;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= (w_rd_state_nxt == RD_IDLE);
            if (w_ar_hs) begin
                r_rdata <= w_rd_word;
                r_rresp <= (w_rsel == SEL_NONE) ? SLVERR : OKAY;
            end
        end
    end

    pu_viol_counter #(.CNT_W(CNT_W)) u_viol_counter (
        .clk             (aclk),
        .rst_n           (aresetn),
        .i_clr           (w_cnt_clr),
        .i_viol_valid    (viol_valid_i),
        .i_viol_addr     (viol_addr_i),
        .i_viol_id       (viol_id_i),
        .i_viol_is_write (viol_is_write_i),
        .o_cnt           (w_viol_cnt),
        .o_addr          (w_viol_addr),
        .o_info          (w_viol_info)
    );

    generate
        for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_policy
            assign policy_wr_o[gi] = r_policy[5'(pol_wr_bit(gi))];
            assign policy_rd_o[gi] = r_policy[5'(pol_rd_bit(gi))];
        end
    endgenerate

    assign policy_upd_o  = r_policy_upd;
    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_wready;
    assign s_axi.bvalid  = (r_wr_state == WR_RESP);
    assign s_axi.bresp   = r_bresp;
    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = (r_rd_state == RD_RESP);
    assign s_axi.rdata   = r_rdata;
    assign s_axi.rresp   = r_rresp;

endmodule

`default_nettype wire
